// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//   Raster-timing bundle carried from the VGA timing generator to the pad
//   drivers and the pixel-content blocks.
//
//   Signals:
//     hsync, vsync   sync pulses (polarity set by the generator)
//     de             visible-area flag
//     sx, sy         current pixel column / line, CW bits each
//     line_start     one-cycle pulse at sx==0
//     frame_start    one-cycle pulse at sx==0, sy==0
//     rgb            12-bit colour {R[3:0],G[3:0],B[3:0]}
//
//   Modports: master (generator drives), slave (consumers read).
interface vga_timing_gen_if #(
    parameter int CW = 10
);
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] sx;
    logic [CW-1:0] sy;
    logic          line_start;
    logic          frame_start;
    logic [11:0]   rgb;

    modport master (
        output hsync, vsync, de, sx, sy, line_start, frame_start, rgb
    );

    modport slave (
        input hsync, vsync, de, sx, sy, line_start, frame_start, rgb
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster timing generator (640x480@60 by default) running on the
//   25 MHz pixel clock. Two counters walk the raster; every output is a
//   registered decode of the counter position, so the coordinate and all of
//   its decodes change on the same edge and the sync outputs are glitch-free.
//
//   Ports:
//     clk_pix    in   pixel clock, the only clock
//     btn_rst_n  in   synchronous active-low reset
//     vga        out  vga_timing_gen_if.master: hsync, vsync, de, sx, sy,
//                     line_start, frame_start, rgb
//
//   Build option:
//     VGA_TIMING_TEST_PATTERN_EN  when defined, rgb carries 8 vertical colour
//                                 bars; otherwise rgb is tied to zero and no
//                                 bar logic exists.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int CW       = 10
) (
    input  logic             clk_pix,
    input  logic             btn_rst_n,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEGIN = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEGIN = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_ACT = (SYNC_POL != 0);

    // Raster position whose decodes are presented on the next edge.
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic          h_last;

    logic          de_d;
    logic          hs_d;
    logic          vs_d;
    logic          ls_d;
    logic          fs_d;

    logic          hsync_q;
    logic          vsync_q;
    logic          de_q;
    logic [CW-1:0] sx_q;
    logic [CW-1:0] sy_q;
    logic          ls_q;
    logic          fs_q;
    logic [11:0]   rgb_q;

    always_comb begin
        h_last = (h_cnt == H_LAST);
        h_nxt  = h_cnt + CW'(1);
        v_nxt  = v_cnt;
        if (h_last) begin
            h_nxt = '0;
            if (v_cnt == V_LAST) begin
                v_nxt = '0;
            end else begin
                v_nxt = v_cnt + CW'(1);
            end
        end
    end

    // Decodes of the current counter position, registered below alongside
    // the coordinate itself so there is no latency between them.
    always_comb begin
        de_d = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_d = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
        vs_d = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
        ls_d = (h_cnt == '0);
        fs_d = (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge clk_pix) begin
        if (!btn_rst_n) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            de_q    <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            hsync_q <= ~SYNC_ACT;
            vsync_q <= ~SYNC_ACT;
        end else begin
            h_cnt   <= h_nxt;
            v_cnt   <= v_nxt;
            sx_q    <= h_cnt;
            sy_q    <= v_cnt;
            de_q    <= de_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            hsync_q <= hs_d ? SYNC_ACT : ~SYNC_ACT;
            vsync_q <= vs_d ? SYNC_ACT : ~SYNC_ACT;
        end
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int            BAR_W    = H_ACTIVE / 8;
    localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);

    // bar_px/bar_idx track the same position as h_cnt: the pixel offset
    // inside the current bar and which bar it is. Past the visible area the
    // index simply wraps; de masks the colour there.
    logic [CW-1:0] bar_px;
    logic [2:0]    bar_idx;
    logic [11:0]   bar_rgb;

    always_comb begin
        bar_rgb = {{4{bar_idx[2]}}, {4{bar_idx[1]}}, {4{bar_idx[0]}}};
    end

    always_ff @(posedge clk_pix) begin
        if (!btn_rst_n) begin
            bar_px  <= '0;
            bar_idx <= '0;
            rgb_q   <= '0;
        end else begin
            if (h_last) begin
                // next position is sx==0: restart at the leftmost bar
                bar_px  <= '0;
                bar_idx <= '0;
            end else if (bar_px == BAR_LAST) begin
                bar_px  <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px  <= bar_px + CW'(1);
            end
            rgb_q <= de_d ? bar_rgb : 12'h000;
        end
    end
`else
    assign rgb_q = 12'h000;
`endif

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.de          = de_q;
    assign vga.sx          = sx_q;
    assign vga.sy          = sy_q;
    assign vga.line_start  = ls_q;
    assign vga.frame_start = fs_q;
    assign vga.rgb         = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam bit PAT_ON = 1'b1;
`else
    localparam bit PAT_ON = 1'b0;
`endif

    logic clk_pix = 1'b0;
    always #20 clk_pix = ~clk_pix;

    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;

    vga_timing_gen_if #(.CW(10)) bus_a ();
    vga_timing_gen_if #(.CW(6))  bus_b ();

    // Full-size 640x480 timing.
    vga_timing_gen dut_a (
        .clk_pix   (clk_pix),
        .btn_rst_n (rst_a_n),
        .vga       (bus_a)
    );

    // Shrunk raster (25x15, active-high sync) so many whole frames fit.
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1),  .CW(6)
    ) dut_b (
        .clk_pix   (clk_pix),
        .btn_rst_n (rst_b_n),
        .vga       (bus_b)
    );

    typedef struct {
        int hs; int vs; int de; int sx; int sy; int ls; int fs; int rgb;
    } vis_t;

    typedef struct {
        int sx; int hs; int de; int ls; int rgb;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;
    int pos_a  = 0;
    int pos_b  = 0;

    int b_valid  = 0;
    int b_cyc    = 0;
    int b_vs     = 0;
    int b_de     = 0;
    int b_ls     = 0;
    int b_frames = 0;

    // Position-based reference: pos = edges since reset release.
    function automatic vis_t ref_out(int pos, bit in_rst, int ha, int hf, int hsw, int hb,
                                     int va, int vf, int vsw, int vbp, int pol);
        vis_t r;
        int   ht, vt, h, v, bar;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vbp;
        r.hs = 1 - pol; r.vs = 1 - pol;
        r.de = 0; r.sx = 0; r.sy = 0; r.ls = 0; r.fs = 0; r.rgb = 0;
        if (in_rst) return r;
        h = pos % ht;
        v = (pos / ht) % vt;
        r.sx = h;
        r.sy = v;
        r.de = (h < ha && v < va) ? 1 : 0;
        r.hs = (h >= ha + hf && h < ha + hf + hsw) ? pol : 1 - pol;
        r.vs = (v >= va + vf && v < va + vf + vsw) ? pol : 1 - pol;
        r.ls = (h == 0) ? 1 : 0;
        r.fs = (h == 0 && v == 0) ? 1 : 0;
        if (PAT_ON && r.de == 1) begin
            bar = h / (ha / 8);
            r.rgb = (((bar & 4) != 0) ? 'hF00 : 0) | (((bar & 2) != 0) ? 'h0F0 : 0)
                  | (((bar & 1) != 0) ? 'h00F : 0);
        end
        return r;
    endfunction

    function automatic vis_t grab_a();
        vis_t r;
        r.hs = int'(bus_a.hsync); r.vs = int'(bus_a.vsync); r.de = int'(bus_a.de);
        r.sx = int'(bus_a.sx); r.sy = int'(bus_a.sy); r.ls = int'(bus_a.line_start);
        r.fs = int'(bus_a.frame_start); r.rgb = int'(bus_a.rgb);
        return r;
    endfunction

    function automatic vis_t grab_b();
        vis_t r;
        r.hs = int'(bus_b.hsync); r.vs = int'(bus_b.vsync); r.de = int'(bus_b.de);
        r.sx = int'(bus_b.sx); r.sy = int'(bus_b.sy); r.ls = int'(bus_b.line_start);
        r.fs = int'(bus_b.frame_start); r.rgb = int'(bus_b.rgb);
        return r;
    endfunction

    task automatic compare(string tag, vis_t act, vis_t exp, int cyc);
        bit bad;
        n_chk++;
        bad = (act.hs != exp.hs) || (act.vs != exp.vs) || (act.de != exp.de)
           || (act.sx != exp.sx) || (act.sy != exp.sy) || (act.ls != exp.ls)
           || (act.fs != exp.fs) || (act.rgb != exp.rgb);
        if (bad) begin
            n_fail++;
            $display("FAIL %s @pos %0d: got hs=%0d vs=%0d de=%0d sx=%0d sy=%0d ls=%0d fs=%0d rgb=%03h, expected hs=%0d vs=%0d de=%0d sx=%0d sy=%0d ls=%0d fs=%0d rgb=%03h",
                     tag, cyc, act.hs, act.vs, act.de, act.sx, act.sy, act.ls, act.fs, act.rgb,
                     exp.hs, exp.vs, exp.de, exp.sx, exp.sy, exp.ls, exp.fs, exp.rgb);
        end
    endtask

    task automatic chk(string tag, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // One pixel clock: drive resets on the falling edge, check both DUTs
    // against the reference just after the rising edge.
    task automatic step(bit ra, bit rb);
        vis_t e;
        @(negedge clk_pix);
        rst_a_n = ra;
        rst_b_n = rb;
        @(posedge clk_pix);
        #1;
        e = ref_out(pos_a, !ra, 640, 16, 96, 48, 480, 10, 2, 33, 0);
        compare("dut_a", grab_a(), e, pos_a);
        pos_a = ra ? pos_a + 1 : 0;
        e = ref_out(pos_b, !rb, 16, 2, 4, 3, 8, 2, 2, 3, 1);
        compare("dut_b", grab_b(), e, pos_b);
        pos_b = rb ? pos_b + 1 : 0;

        // Whole-frame statistics on the small raster, frame_start to frame_start.
        if (!rb) begin
            b_valid = 0;
        end else begin
            if (bus_b.frame_start) begin
                if (b_valid != 0) begin
                    chk("b_frame_len", b_cyc, 375);
                    chk("b_vsync_cycles", b_vs, 50);
                    chk("b_de_cycles", b_de, 128);
                    chk("b_line_starts", b_ls, 15);
                    b_frames++;
                end
                b_valid = 1; b_cyc = 0; b_vs = 0; b_de = 0; b_ls = 0;
            end
            b_cyc++;
            b_vs += (bus_b.vsync == 1'b1) ? 1 : 0;
            b_de += int'(bus_b.de);
            b_ls += int'(bus_b.line_start);
        end
    endtask

    function automatic bit rand_rb();
        return ($urandom_range(0, 1499) != 0);
    endfunction

    task automatic run_a_to(int target, string tag);
        int guard;
        guard = 0;
        while (pos_a != target + 1 && guard < 20000) begin
            step(1'b1, rand_rb());
            guard++;
        end
        if (pos_a != target + 1) chk({tag, "_reach_timeout"}, pos_a, target + 1);
    endtask

    vec_t tab[15];

    initial begin
        int hs_low, de_hi, ls_cnt;

        // line sy=10 of the full raster: {sx, hsync, de, line_start, bar colour}
        tab[0]  = '{0,   1, 1, 1, 'h000};
        tab[1]  = '{79,  1, 1, 0, 'h000};
        tab[2]  = '{80,  1, 1, 0, 'h00F};
        tab[3]  = '{159, 1, 1, 0, 'h00F};
        tab[4]  = '{160, 1, 1, 0, 'h0F0};
        tab[5]  = '{320, 1, 1, 0, 'hF00};
        tab[6]  = '{399, 1, 1, 0, 'hF00};
        tab[7]  = '{560, 1, 1, 0, 'hFFF};
        tab[8]  = '{639, 1, 1, 0, 'hFFF};
        tab[9]  = '{640, 1, 0, 0, 'h000};
        tab[10] = '{655, 1, 0, 0, 'h000};
        tab[11] = '{656, 0, 0, 0, 'h000};
        tab[12] = '{751, 0, 0, 0, 'h000};
        tab[13] = '{752, 1, 0, 0, 'h000};
        tab[14] = '{799, 1, 0, 0, 'h000};
        for (int i = 0; i < 15; i++) begin
            if (!PAT_ON) tab[i].rgb = 0;
        end

        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        chk("rst_de", int'(bus_a.de), 0);
        chk("rst_hsync", int'(bus_a.hsync), 1);
        chk("rst_vsync", int'(bus_a.vsync), 1);
        chk("rst_sx", int'(bus_a.sx), 0);
        chk("rst_sy", int'(bus_a.sy), 0);

        step(1'b1, 1'b1);
        chk("rel_sx", int'(bus_a.sx), 0);
        chk("rel_sy", int'(bus_a.sy), 0);
        chk("rel_de", int'(bus_a.de), 1);
        chk("rel_frame_start", int'(bus_a.frame_start), 1);
        chk("rel_line_start", int'(bus_a.line_start), 1);

        // rest of line 0
        hs_low = (bus_a.hsync == 1'b0) ? 1 : 0;
        de_hi  = int'(bus_a.de);
        ls_cnt = int'(bus_a.line_start);
        for (int i = 1; i < 800; i++) begin
            step(1'b1, rand_rb());
            hs_low += (bus_a.hsync == 1'b0) ? 1 : 0;
            de_hi  += int'(bus_a.de);
            ls_cnt += int'(bus_a.line_start);
        end
        chk("line0_hsync_low", hs_low, 96);
        chk("line0_de_high", de_hi, 640);
        chk("line0_line_starts", ls_cnt, 1);
        step(1'b1, rand_rb());
        chk("line1_sx", int'(bus_a.sx), 0);
        chk("line1_sy", int'(bus_a.sy), 1);
        chk("line1_line_start", int'(bus_a.line_start), 1);

        for (int i = 0; i < 15; i++) begin
            run_a_to(10 * 800 + tab[i].sx, "tab");
            chk($sformatf("tab_sx%0d_sx", tab[i].sx), int'(bus_a.sx), tab[i].sx);
            chk($sformatf("tab_sx%0d_hsync", tab[i].sx), int'(bus_a.hsync), tab[i].hs);
            chk($sformatf("tab_sx%0d_de", tab[i].sx), int'(bus_a.de), tab[i].de);
            chk($sformatf("tab_sx%0d_line_start", tab[i].sx), int'(bus_a.line_start), tab[i].ls);
            chk($sformatf("tab_sx%0d_rgb", tab[i].sx), int'(bus_a.rgb), tab[i].rgb);
        end

        // one-cycle reset in the middle of hsync
        run_a_to(11 * 800 + 700, "midrst");
        chk("midrst_pre_hsync", int'(bus_a.hsync), 0);
        step(1'b0, rand_rb());
        chk("midrst_hsync", int'(bus_a.hsync), 1);
        chk("midrst_de", int'(bus_a.de), 0);
        chk("midrst_sx", int'(bus_a.sx), 0);
        chk("midrst_sy", int'(bus_a.sy), 0);
        chk("midrst_frame_start", int'(bus_a.frame_start), 0);
        step(1'b1, rand_rb());
        chk("restart_sx", int'(bus_a.sx), 0);
        chk("restart_sy", int'(bus_a.sy), 0);
        chk("restart_de", int'(bus_a.de), 1);
        chk("restart_frame_start", int'(bus_a.frame_start), 1);

        for (int i = 0; i < 3000; i++) step(1'b1, rand_rb());
        chk("b_min_frames", (b_frames >= 5) ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
